// File: rtl/pic_jump_ctrl.sv
// pic_jump_ctrl: bouncing-picture position controller with picture ROM address generation.
// Defining PIC_JUMP_PAUSE_EN adds a "pause" input that freezes motion at frame-end ticks.
module pic_jump_ctrl #(
  parameter int H_VALID = 640,
  parameter int V_VALID = 480,
  parameter int PIC_W   = 100,
  parameter int PIC_H   = 100,
  parameter int STEP    = 2,
  parameter int FRM_DIV = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
`ifdef PIC_JUMP_PAUSE_EN
  input  logic        pause,
`endif
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [13:0] rom_addr,
  output logic        rom_rd_en,
  output logic        pic_valid,
  output logic [9:0]  pic_x,
  output logic [9:0]  pic_y,
  output logic [1:0]  dir
);

  typedef enum logic [1:0] {
    DR = 2'b00,
    UR = 2'b01,
    DL = 2'b10,
    UL = 2'b11
  } dir_state_t;

  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [10:0] X_MAX11  = 11'(H_VALID - PIC_W);
  localparam logic [10:0] Y_MAX11  = 11'(V_VALID - PIC_H);
  localparam logic [10:0] PIC_W11  = 11'(PIC_W);
  localparam logic [10:0] PIC_H11  = 11'(PIC_H);
  localparam logic [13:0] PIC_W14  = 14'(PIC_W);
  localparam logic [7:0]  FRM_LAST = 8'(FRM_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_VALID - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_VALID - 1);
  localparam logic [9:0]  PIX_NONE = 10'h3FF;

  // One axis of the bounce: returns {new direction bit, new position}.
  // Direction bit 0 means moving towards larger coordinates.
  function automatic logic [10:0] step_axis(input logic [9:0]  pos,
                                            input logic        back,
                                            input logic [10:0] limit);
    logic [10:0] pos_ext;
    logic [10:0] sum;
    pos_ext = {1'b0, pos};
    sum     = pos_ext + STEP11;
    if (!back) begin
      if (sum >= limit) step_axis = {1'b1, limit[9:0]};
      else              step_axis = {1'b0, sum[9:0]};
    end else begin
      if (pos_ext <= STEP11) step_axis = {1'b0, 10'd0};
      else                   step_axis = {1'b1, pos - STEP11[9:0]};
    end
  endfunction

  dir_state_t  state_r;
  dir_state_t  state_next_s;
  logic [9:0]  pic_x_r, pic_y_r;
  logic [7:0]  frm_cnt_r;
  logic        tick_s;
  logic        hold_s;
  logic        in_win_s;
  logic [10:0] x_step_s, y_step_s;
  logic [10:0] pix_x_ext_s, pix_y_ext_s, pic_x_ext_s, pic_y_ext_s;
  logic [13:0] rel_x_s, rel_y_s;
  logic [13:0] rom_addr_next_s;
  logic [13:0] rom_addr_r;
  logic        rom_rd_en_r;
  logic        pic_valid_r;

`ifdef PIC_JUMP_PAUSE_EN
  assign hold_s = pause;
`else
  assign hold_s = 1'b0;
`endif

  // Frame-end detection, candidate next position and window test / ROM address
  always_comb begin
    tick_s       = (pix_x == H_LAST) && (pix_y == V_LAST);
    x_step_s     = step_axis(pic_x_r, state_r[1], X_MAX11);
    y_step_s     = step_axis(pic_y_r, state_r[0], Y_MAX11);
    state_next_s = dir_state_t'({x_step_s[10], y_step_s[10]});
    pix_x_ext_s  = {1'b0, pix_x};
    pix_y_ext_s  = {1'b0, pix_y};
    pic_x_ext_s  = {1'b0, pic_x_r};
    pic_y_ext_s  = {1'b0, pic_y_r};
    // Blanking coordinates are excluded explicitly, not just by geometry.
    in_win_s     = (pix_x != PIX_NONE) && (pix_y != PIX_NONE) &&
                   (pix_x_ext_s >= pic_x_ext_s) && (pix_x_ext_s < pic_x_ext_s + PIC_W11) &&
                   (pix_y_ext_s >= pic_y_ext_s) && (pix_y_ext_s < pic_y_ext_s + PIC_H11);
    rel_x_s      = {3'b000, pix_x_ext_s - pic_x_ext_s};
    rel_y_s      = {3'b000, pix_y_ext_s - pic_y_ext_s};
    if (in_win_s) begin
      rom_addr_next_s = rel_y_s * PIC_W14 + rel_x_s;
    end else begin
      rom_addr_next_s = 14'd0;
    end
  end

  // Direction FSM, position and frame divider; moves only at frame end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r   <= DR;
      pic_x_r   <= 10'd0;
      pic_y_r   <= 10'd0;
      frm_cnt_r <= 8'd0;
    end else if (tick_s && !hold_s) begin
      if (frm_cnt_r >= FRM_LAST) begin
        frm_cnt_r <= 8'd0;
        state_r   <= state_next_s;
        pic_x_r   <= x_step_s[9:0];
        pic_y_r   <= y_step_s[9:0];
      end else begin
        frm_cnt_r <= frm_cnt_r + 8'd1;
      end
    end
  end

  // ROM request stage and valid delay matching the ROM read latency
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rom_addr_r  <= 14'd0;
      rom_rd_en_r <= 1'b0;
      pic_valid_r <= 1'b0;
    end else begin
      rom_addr_r  <= rom_addr_next_s;
      rom_rd_en_r <= in_win_s;
      pic_valid_r <= rom_rd_en_r;
    end
  end

  assign rom_addr  = rom_addr_r;
  assign rom_rd_en = rom_rd_en_r;
  assign pic_valid = pic_valid_r;
  assign pic_x     = pic_x_r;
  assign pic_y     = pic_y_r;
  assign dir       = state_r;

endmodule

// File: tb/tb_pic_jump_ctrl.sv
// Directed bench for pic_jump_ctrl: one FRM_DIV=1 instance and one FRM_DIV=3 instance
// sharing the scan inputs; pause scenario included when PIC_JUMP_PAUSE_EN is defined.
module tb_pic_jump_ctrl;

  logic        sys_clk;
  logic        sys_rst;
`ifdef PIC_JUMP_PAUSE_EN
  logic        pause;
`endif
  logic [9:0]  pix_x, pix_y;
  logic [13:0] rom_addr, rom_addr3;
  logic        rom_rd_en, rom_rd_en3;
  logic        pic_valid, pic_valid3;
  logic [9:0]  pic_x, pic_y, pic_x3, pic_y3;
  logic [1:0]  dir, dir3;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int k        = 0;

  pic_jump_ctrl #(.FRM_DIV(1)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
`ifdef PIC_JUMP_PAUSE_EN
    .pause    (pause),
`endif
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .rom_addr (rom_addr),
    .rom_rd_en(rom_rd_en),
    .pic_valid(pic_valid),
    .pic_x    (pic_x),
    .pic_y    (pic_y),
    .dir      (dir)
  );

  pic_jump_ctrl #(.FRM_DIV(3)) dut3 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
`ifdef PIC_JUMP_PAUSE_EN
    .pause    (pause),
`endif
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .rom_addr (rom_addr3),
    .rom_rd_en(rom_rd_en3),
    .pic_valid(pic_valid3),
    .pic_x    (pic_x3),
    .pic_y    (pic_y3),
    .dir      (dir3)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // One frame-end tick followed by a blanking cycle; k counts ticks since reset.
  task automatic tick();
    pix_x = 10'd639;
    pix_y = 10'd479;
    cyc();
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
    cyc();
    k++;
  endtask

  task automatic check_pos(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                           input logic [1:0] ed);
    check({tag, ".x"}, 32'(pic_x), 32'(ex));
    check({tag, ".y"}, 32'(pic_y), 32'(ey));
    check({tag, ".dir"}, 32'(dir), 32'(ed));
  endtask

  initial begin
    sys_rst = 1'b1;
`ifdef PIC_JUMP_PAUSE_EN
    pause = 1'b0;
`endif
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
    cyc();
    cyc();
    sys_rst = 1'b0;

    // Reset state
    check_pos("rst", 10'd0, 10'd0, 2'b00);
    check("rst.addr", 32'(rom_addr), 32'd0);
    check("rst.rd_en", 32'(rom_rd_en), 32'd0);
    check("rst.valid", 32'(pic_valid), 32'd0);
    check("rst.x3", 32'(pic_x3), 32'd0);

    // ROM addressing with the picture at 0,0
    pix_x = 10'd99; pix_y = 10'd99;
    cyc();
    check("rom99.rd_en", 32'(rom_rd_en), 32'd1);
    check("rom99.addr", 32'(rom_addr), 32'd9999);
    check("rom99.valid0", 32'(pic_valid), 32'd0);
    pix_x = 10'd100; pix_y = 10'd99;
    cyc();
    check("rom99.valid1", 32'(pic_valid), 32'd1);
    check("rom100.rd_en", 32'(rom_rd_en), 32'd0);
    check("rom100.addr", 32'(rom_addr), 32'd0);
    pix_x = 10'd50; pix_y = 10'd2;
    cyc();
    check("rom250.addr", 32'(rom_addr), 32'd250);
    check("rom250.rd_en", 32'(rom_rd_en), 32'd1);
    check("rom100.valid", 32'(pic_valid), 32'd0);
    pix_x = 10'd0; pix_y = 10'h3FF;
    cyc();
    check("blank_y.rd_en", 32'(rom_rd_en), 32'd0);
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    cyc();
    check("blank_xy.rd_en", 32'(rom_rd_en), 32'd0);

    // Three frames: 2,2 then 4,4; divided instance moves only on the 3rd tick
    tick();
    check_pos("frm1", 10'd2, 10'd2, 2'b00);
    check("frm1.x3", 32'(pic_x3), 32'd0);
    tick();
    check_pos("frm2", 10'd4, 10'd4, 2'b00);
    check("frm2.x3", 32'(pic_x3), 32'd0);
    tick();
    check("frm3.x3", 32'(pic_x3), 32'd2);
    check("frm3.y3", 32'(pic_y3), 32'd2);
    check("frm3.x", 32'(pic_x), 32'd6);

    // Window follows the moved picture (dut at 6,6; dut3 at 2,2)
    pix_x = 10'd5; pix_y = 10'd6;
    cyc();
    check("win5.rd_en", 32'(rom_rd_en), 32'd0);
    check("win5.addr3", 32'(rom_addr3), 32'd403);
    check("win5.rd_en3", 32'(rom_rd_en3), 32'd1);
    pix_x = 10'd6; pix_y = 10'd6;
    cyc();
    check("win6.rd_en", 32'(rom_rd_en), 32'd1);
    check("win6.addr", 32'(rom_addr), 32'd0);

    // Mid-frame reset with a pending division count of 2
    tick();
    tick();
    check("pre_rst.x3", 32'(pic_x3), 32'd2);
    pix_x = 10'd20; pix_y = 10'd20;
    cyc();
    cyc();
    check("pre_rst.rd_en", 32'(rom_rd_en), 32'd1);
    check("pre_rst.valid", 32'(pic_valid), 32'd1);
    check("pre_rst.addr", 32'(rom_addr), 32'd1010);
    sys_rst = 1'b1;
    cyc();
    check_pos("mid_rst", 10'd0, 10'd0, 2'b00);
    check("mid_rst.addr", 32'(rom_addr), 32'd0);
    check("mid_rst.rd_en", 32'(rom_rd_en), 32'd0);
    check("mid_rst.valid", 32'(pic_valid), 32'd0);
    check("mid_rst.y3", 32'(pic_y3), 32'd0);
    sys_rst = 1'b0;
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    k = 0;
    tick();
    check("post_rst1.x3", 32'(pic_x3), 32'd0);
    check_pos("post_rst1", 10'd2, 10'd2, 2'b00);
    tick();
    check("post_rst2.x3", 32'(pic_x3), 32'd0);
    tick();
    check("post_rst3.x3", 32'(pic_x3), 32'd2);

    // Right edge: 269 updates reach 538, the 270th clamps to 540 and turns left
    while (k < 269) tick();
    check("edge269.x", 32'(pic_x), 32'd538);
    check("edge269.dir1", 32'(dir[1]), 32'd0);
    tick();
    check_pos("edge270", 10'd540, 10'd220, 2'b11);
    tick();
    check("edge271.x", 32'(pic_x), 32'd538);

    // Update 5129 sits at 538,378 moving DR; the next one hits the corner
    while (k < 5129) tick();
    check_pos("pre_corner", 10'd538, 10'd378, 2'b00);
    tick();
    check_pos("corner", 10'd540, 10'd380, 2'b11);

`ifdef PIC_JUMP_PAUSE_EN
    pause = 1'b1;
    tick();
    pix_x = 10'd600; pix_y = 10'd400;
    cyc();
    check("pause.rd_en", 32'(rom_rd_en), 32'd1);
    check("pause.addr", 32'(rom_addr), 32'd2060);
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    cyc();
    check("pause.rd_en_off", 32'(rom_rd_en), 32'd0);
    tick();
    check_pos("pause2", 10'd540, 10'd380, 2'b11);
    pause = 1'b0;
    tick();
    check_pos("unpause", 10'd538, 10'd378, 2'b11);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
